// File: rtl/port_in_cond.sv
// port_in_cond: four-channel input conditioner in front of CPU ports p0..p3.
// Each raw bus is synchronised, debounced, then registered onto p0..p3.
//
// Ports:
//   clk            rising-edge system clock
//   reset          asynchronous active-low reset
//   raw0..raw3     asynchronous external buses, WIDTH bits each
//   chg_clr[3:0]   per-channel clear of the sticky change flag
//   p0..p3         settled, clock-aligned channel values
//   chg[3:0]       sticky per-channel "output changed" flags
module port_in_cond #(
   parameter int WIDTH         = 16,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw0,
   input  logic [WIDTH-1:0] raw1,
   input  logic [WIDTH-1:0] raw2,
   input  logic [WIDTH-1:0] raw3,
   input  logic [3:0]       chg_clr,
   output logic [WIDTH-1:0] p0,
   output logic [WIDTH-1:0] p1,
   output logic [WIDTH-1:0] p2,
   output logic [WIDTH-1:0] p3,
   output logic [3:0]       chg
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] raw    [4];
   logic [WIDTH-1:0] s1_q   [4];
   logic [WIDTH-1:0] s2_q   [4];
   logic [WIDTH-1:0] cand_q [4];
   logic [WIDTH-1:0] cand_d [4];
   logic [WIDTH-1:0] p_q    [4];
   logic [WIDTH-1:0] p_d    [4];
   logic [CNT_W-1:0] cnt_q  [4];
   logic [CNT_W-1:0] cnt_d  [4];
   logic [3:0]       chg_q;
   logic [3:0]       chg_d;
   logic [3:0]       upd;

   assign raw[0] = raw0;
   assign raw[1] = raw1;
   assign raw[2] = raw2;
   assign raw[3] = raw3;

   always_comb begin
      for (int n = 0; n < 4; n++) begin
         cand_d[n] = cand_q[n];
         cnt_d[n]  = cnt_q[n];
         p_d[n]    = p_q[n];
         upd[n]    = 1'b0;
         if (s2_q[n] != cand_q[n]) begin
            // any movement restarts qualification
            cand_d[n] = s2_q[n];
            cnt_d[n]  = '0;
         end else if (cnt_q[n] != CNT_MAX) begin
            cnt_d[n] = cnt_q[n] + CNT_W'(1);
         end else if (p_q[n] != cand_q[n]) begin
            // counter saturated: candidate has settled
            p_d[n] = cand_q[n];
            upd[n] = 1'b1;
         end
      end
      // a new change event wins over a same-cycle clear
      chg_d = (chg_q & ~chg_clr) | upd;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int n = 0; n < 4; n++) begin
            s1_q[n]   <= '0;
            s2_q[n]   <= '0;
            cand_q[n] <= '0;
            cnt_q[n]  <= '0;
            p_q[n]    <= '0;
         end
         chg_q <= '0;
      end else begin
         for (int n = 0; n < 4; n++) begin
            s1_q[n]   <= raw[n];
            s2_q[n]   <= s1_q[n];
            cand_q[n] <= cand_d[n];
            cnt_q[n]  <= cnt_d[n];
            p_q[n]    <= p_d[n];
         end
         chg_q <= chg_d;
      end
   end

   assign p0  = p_q[0];
   assign p1  = p_q[1];
   assign p2  = p_q[2];
   assign p3  = p_q[3];
   assign chg = chg_q;

endmodule

// File: tb/tb_port_in_cond.sv
// tb_port_in_cond: scoreboard bench for port_in_cond.
// Runs a 4-cycle and a 1-cycle debounce build side by side.
module tb_port_in_cond;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] raw [4];
   logic [3:0]   chg_clr;
   logic [W-1:0] pa [4];
   logic [W-1:0] pb [4];
   logic [3:0]   chga;
   logic [3:0]   chgb;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   port_in_cond #(.WIDTH(16), .STABLE_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .raw0(raw[0]), .raw1(raw[1]), .raw2(raw[2]), .raw3(raw[3]),
      .chg_clr(chg_clr),
      .p0(pa[0]), .p1(pa[1]), .p2(pa[2]), .p3(pa[3]),
      .chg(chga)
   );

   port_in_cond #(.WIDTH(16), .STABLE_CYCLES(1), .CNT_W(8)) dut1 (
      .clk(clk), .reset(reset),
      .raw0(raw[0]), .raw1(raw[1]), .raw2(raw[2]), .raw3(raw[3]),
      .chg_clr(chg_clr),
      .p0(pb[0]), .p1(pb[1]), .p2(pb[2]), .p3(pb[3]),
      .chg(chgb)
   );

   typedef struct packed {
      logic [3:0][W-1:0] p;
      logic [3:0]        chg;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   // reference model: the value the synchroniser shows two edges late,
   // how long it has persisted, and each build's accepted outputs
   logic [W-1:0] hist [4][$];
   logic [W-1:0] run_val [4];
   int           run_len [4];
   logic [W-1:0] mp [2][4];
   logic [3:0]   mchg [2];

   function automatic int sc_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < 4; c++) begin
         hist[c].delete();
         hist[c].push_back('0);
         hist[c].push_back('0);
         run_val[c] = '0;
         run_len[c] = 1;
         mp[0][c] = '0;
         mp[1][c] = '0;
      end
      mchg[0] = '0;
      mchg[1] = '0;
   endfunction

   function automatic void model_edge(input logic [3:0] clr);
      logic [3:0]   set [2];
      logic [W-1:0] x;
      set[0] = '0;
      set[1] = '0;
      for (int c = 0; c < 4; c++) begin
         hist[c].push_back(raw[c]);
         x = hist[c].pop_front();
         if (x == run_val[c]) begin
            if (run_len[c] < 1000) run_len[c]++;
         end else begin
            run_val[c] = x;
            run_len[c] = 1;
         end
         // a value seen for SC+1 consecutive samples is accepted
         for (int i = 0; i < 2; i++) begin
            if (run_len[c] >= sc_of(i) + 1 && mp[i][c] != run_val[c]) begin
               mp[i][c] = run_val[c];
               set[i][c] = 1'b1;
            end
         end
      end
      for (int i = 0; i < 2; i++)
         mchg[i] = (mchg[i] & ~clr) | set[i];
   endfunction

   function automatic exp_t snap(input int i);
      exp_t e;
      for (int c = 0; c < 4; c++) e.p[c] = mp[i][c];
      e.chg = mchg[i];
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (!reset) model_reset();
      else model_edge(chg_clr);
      qa.push_back(snap(0));
      qb.push_back(snap(1));
      #1;
   endtask

   // asserted between edges, after the monitor has sampled
   task automatic async_reset();
      @(negedge clk);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
   endtask

   task automatic measure(input int ch, input logic [W-1:0] v,
                          output int na, output int nb);
      na = -1;
      nb = -1;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (na < 0 && pa[ch] == v) na = k;
         if (nb < 0 && pb[ch] == v) nb = k;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (qa.size() > 0) begin
         e = qa.pop_front();
         for (int c = 0; c < 4; c++)
            chk($sformatf("sb4 p%0d", c), 32'(pa[c]), 32'(e.p[c]));
         chk("sb4 chg", 32'(chga), 32'(e.chg));
      end
      if (qb.size() > 0) begin
         e = qb.pop_front();
         for (int c = 0; c < 4; c++)
            chk($sformatf("sb1 p%0d", c), 32'(pb[c]), 32'(e.p[c]));
         chk("sb1 chg", 32'(chgb), 32'(e.chg));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      int na, nb;
      logic [W-1:0] v;
      int hold [4];

      // 1: reset value and first-acceptance latency
      reset = 1'b0;
      chg_clr = '0;
      for (int c = 0; c < 4; c++) raw[c] = '0;
      raw[0] = 16'hFFFF;
      model_reset();
      repeat (3) step();
      chk("rst p0", 32'(pa[0]), 32'h0);
      chk("rst chg", 32'(chga), 32'h0);
      reset = 1'b1;
      measure(0, 16'hFFFF, na, nb);
      chk("lat4 t1", na, 7);
      chk("lat1 t1", nb, 4);
      chk("chg t1", 32'(chga), 32'h1);

      // 2: short excursion is rejected
      raw[1] = 16'h00A5;
      repeat (10) step();
      chg_clr = 4'b1111;
      step();
      chg_clr = '0;
      raw[1] = 16'h5AFF;
      repeat (3) begin
         step();
         chk("excur p1", 32'(pa[1]), 32'h00A5);
      end
      raw[1] = 16'h00A5;
      repeat (10) begin
         step();
         chk("return p1", 32'(pa[1]), 32'h00A5);
      end
      chk("return chg1", 32'(chga[1]), 32'h0);

      // 3: bouncing restarts the count
      for (int i = 0; i < 10; i++) begin
         raw[2] = (i % 2 == 0) ? 16'h0001 : 16'h0000;
         repeat (2) begin
            step();
            chk("bounce p2", 32'(pa[2]), 32'h0);
         end
      end
      raw[2] = 16'h0001;
      measure(2, 16'h0001, na, nb);
      chk("lat4 t3", na, 7);
      chk("chg2 t3", 32'(chga[2]), 32'h1);
      chg_clr = 4'b0100;
      step();
      chg_clr = '0;
      repeat (10) step();
      chk("chg2 once", 32'(chga[2]), 32'h0);

      // 4: set beats a same-edge clear
      raw[3] = 16'h1234;
      repeat (10) step();
      chk("chg3 set", 32'(chga[3]), 32'h1);
      raw[3] = 16'h4321;
      repeat (6) step();
      chk("p3 hold", 32'(pa[3]), 32'h1234);
      chg_clr = 4'b1000;
      step();
      chg_clr = '0;
      chk("p3 upd", 32'(pa[3]), 32'h4321);
      chk("chg3 win", 32'(chga[3]), 32'h1);
      chg_clr = 4'b1000;
      step();
      chg_clr = '0;
      chk("chg3 clr", 32'(chga[3]), 32'h0);

      // 5: async reset during qualification
      raw[0] = 16'h0F0F;
      repeat (5) step();
      async_reset();
      chk("async p0", 32'(pa[0]), 32'h0);
      chk("async chg", 32'(chga), 32'h0);
      chk("async p0 b", 32'(pb[0]), 32'h0);
      repeat (2) step();
      reset = 1'b1;
      measure(0, 16'h0F0F, na, nb);
      chk("lat4 t5", na, 7);
      chk("lat1 t5", nb, 4);

      // 6: all channels at once
      async_reset();
      raw[0] = 16'h1111;
      raw[1] = 16'h2222;
      raw[2] = 16'h3333;
      raw[3] = 16'h4444;
      repeat (2) step();
      reset = 1'b1;
      na = -1;
      nb = -1;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (na < 0 && pa[0] == 16'h1111 && pa[1] == 16'h2222 &&
             pa[2] == 16'h3333 && pa[3] == 16'h4444) na = k;
         if (nb < 0 && pb[0] == 16'h1111 && pb[1] == 16'h2222 &&
             pb[2] == 16'h3333 && pb[3] == 16'h4444) nb = k;
      end
      chk("lat4 all", na, 7);
      chk("lat1 all", nb, 4);
      chk("chg all4", 32'(chga), 32'hF);
      chk("chg all1", 32'(chgb), 32'hF);

      // random bounce lengths, clears and resets
      for (int c = 0; c < 4; c++) hold[c] = 0;
      for (int t = 0; t < 1500; t++) begin
         for (int c = 0; c < 4; c++) begin
            if (hold[c] == 0) begin
               case ($urandom_range(0, 4))
                  0: v = 16'h0000;
                  1: v = 16'hFFFF;
                  2: v = 16'h00A5;
                  3: v = 16'h5AFF;
                  default: v = 16'($urandom);
               endcase
               raw[c] = v;
               hold[c] = $urandom_range(1, 8);
            end else begin
               hold[c]--;
            end
         end
         chg_clr = ($urandom_range(0, 3) == 0) ?
                   4'($urandom_range(0, 15)) : 4'b0;
         step();
         if ($urandom_range(0, 399) == 0) begin
            async_reset();
            step();
            reset = 1'b1;
         end
      end

      chg_clr = '0;
      step();
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
